// File: rtl/cmd_link_pkg.sv
// Shared definitions for the 8-bit latched command link (encoder and decoder sides).
// Command byte codes, command index enum and encoder FSM state type.
package cmd_link_pkg;

    localparam logic [7:0] CMD_RESET  = 8'hAA;
    localparam logic [7:0] CMD_NFRAME = 8'h55;
    localparam logic [7:0] CMD_USB    = 8'h5A;
    localparam logic [7:0] CMD_SD     = 8'hA5;
    localparam logic [7:0] CMD_IDLE   = 8'h00;

    localparam int NUM_CMDS = 4;

    typedef enum logic [1:0] {
        IDX_RESET  = 2'd0,
        IDX_NFRAME = 2'd1,
        IDX_USB    = 2'd2,
        IDX_SD     = 2'd3
    } cmd_idx_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_GAP   = 2'd2
    } enc_state_e;

    function automatic logic [7:0] cmd_code(input cmd_idx_e idx);
        case (idx)
            IDX_RESET:  return CMD_RESET;
            IDX_NFRAME: return CMD_NFRAME;
            IDX_USB:    return CMD_USB;
            default:    return CMD_SD;
        endcase
    endfunction

endpackage

// File: rtl/cmd_priority_arbiter.sv
// Fixed-priority selector for queued link commands: reset > nframe > usb > sd.
// Purely combinational; returns a one-hot grant and the matching command byte.
module cmd_priority_arbiter
    import cmd_link_pkg::*;
(
    input  logic [NUM_CMDS-1:0] pending,
    output logic [NUM_CMDS-1:0] grant,
    output logic [7:0]          code
);

    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        grant = '0;
        code  = CMD_IDLE;
        if (pending[IDX_RESET]) begin
            grant[IDX_RESET] = 1'b1;
            code             = cmd_code(IDX_RESET);
        end else if (pending[IDX_NFRAME]) begin
            grant[IDX_NFRAME] = 1'b1;
            code              = cmd_code(IDX_NFRAME);
        end else if (pending[IDX_USB]) begin
            grant[IDX_USB] = 1'b1;
            code           = cmd_code(IDX_USB);
        end else if (pending[IDX_SD]) begin
            grant[IDX_SD] = 1'b1;
            code          = cmd_code(IDX_SD);
        end
    end

endmodule

// File: rtl/fpga_command_encoder.sv
// Transmit side of the latched command link: queues request pulses and frames each byte
// with a command_latch strobe followed by a low gap. Optional raw-byte path: CMD_ENC_RAW_EN.
module fpga_command_encoder
    import cmd_link_pkg::*;
#(
    parameter int LATCH_CYCLES = 2,
    parameter int GAP_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_reset,
    input  logic       req_nframe,
    input  logic       req_usb,
    input  logic       req_sd,
    output logic       command_latch,
    output logic [7:0] command_data,
    output logic [3:0] pending,
    output logic       busy,
    output logic       cmd_done
`ifdef CMD_ENC_RAW_EN
    ,
    input  logic       raw_valid,
    input  logic [7:0] raw_data,
    output logic       raw_ready
`endif
);

    enc_state_e    state;
    logic [7:0]    counter;
    logic [3:0]    req_vec;
    logic [3:0]    grant;
    logic [7:0]    arb_code;
    logic          launch_cmd;
    logic [3:0]    pending_next;

    cmd_priority_arbiter u_arbiter (
        .pending (pending),
        .grant   (grant),
        .code    (arb_code)
    );

    // A request on the launch cycle wins over the clear, so it is sent again later.
    always_comb begin
        req_vec      = {req_sd, req_usb, req_nframe, req_reset};
        launch_cmd   = (state == ST_IDLE) && (pending != 4'b0000);
        pending_next = (pending & ~(launch_cmd ? grant : 4'b0000)) | req_vec;
    end

    // NOTE: all state below uses non-blocking assignments so every register updates together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            counter       <= 8'd0;
            pending       <= 4'b0000;
            command_latch <= 1'b0;
            command_data  <= CMD_IDLE;
            busy          <= 1'b0;
            cmd_done      <= 1'b0;
`ifdef CMD_ENC_RAW_EN
            raw_ready     <= 1'b0;
`endif
        end else begin
            pending  <= pending_next;
            cmd_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (launch_cmd) begin
                        state         <= ST_LATCH;
                        counter       <= 8'd1;
                        command_latch <= 1'b1;
                        command_data  <= arb_code;
                        busy          <= 1'b1;
`ifdef CMD_ENC_RAW_EN
                        raw_ready     <= 1'b0;
                    end else if (raw_valid && raw_ready) begin
                        if (raw_data != CMD_IDLE) begin
                            state         <= ST_LATCH;
                            counter       <= 8'd1;
                            command_latch <= 1'b1;
                            command_data  <= raw_data;
                            busy          <= 1'b1;
                            raw_ready     <= 1'b0;
                        end else begin
                            // A zero byte would be indistinguishable from idle, so skip the strobe.
                            cmd_done      <= 1'b1;
                            command_latch <= 1'b0;
                            command_data  <= CMD_IDLE;
                            raw_ready     <= (pending_next == 4'b0000);
                        end
`endif
                    end else begin
                        command_latch <= 1'b0;
                        command_data  <= CMD_IDLE;
`ifdef CMD_ENC_RAW_EN
                        raw_ready     <= (pending_next == 4'b0000);
`endif
                    end
                end
                ST_LATCH: begin
                    if (counter == 8'(LATCH_CYCLES)) begin
                        state         <= ST_GAP;
                        counter       <= 8'd1;
                        command_latch <= 1'b0;
                        command_data  <= CMD_IDLE;
                    end else begin
                        counter <= counter + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (counter == 8'(GAP_CYCLES)) begin
                        state    <= ST_IDLE;
                        counter  <= 8'd0;
                        busy     <= 1'b0;
                        cmd_done <= 1'b1;
`ifdef CMD_ENC_RAW_EN
                        raw_ready <= (pending_next == 4'b0000);
`endif
                    end else begin
                        counter <= counter + 8'd1;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    counter       <= 8'd0;
                    command_latch <= 1'b0;
                    command_data  <= CMD_IDLE;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule
